io_responder: RTL and testbench
===============================

# io_responder

Responder end of the CPU's IN/OUT instruction interface. It takes the control-unit I/O command code, serves IN by waiting for an operator button press and returning the 4-bit switch value as a 32-bit word, and serves OUT by converting the written word into three BCD digits for the seven-segment decoders. While a command is in progress it holds `ocupado` high, which the halt logic uses to freeze the PC. Completion is signalled with a one-cycle `pronto` pulse.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before the debounced button level changes (used only with debounce compiled in).
- `DATA_W`, 32: data word width.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- `entradaSaidaControl`  in  2  command: 00 idle, 01 IN, 10 OUT, 11 reserved (ignored).
- `dadosEscrita`  in  DATA_W  value to display on OUT; sampled on the accepting edge.
- `entradaDeDados`  in  4  raw switch value; sampled when a press is detected.
- `botaoPlaca`  in  1  raw push button, active-high, asynchronous to `clock`.
- `dadosLidos`  out  DATA_W  last IN value, zero-extended; reset 0.
- `ocupado`  out  1  high from the accepting edge until `pronto` falls; reset 0.
- `pronto`  out  1  one-cycle completion pulse; reset 0.
- `unidade`, `dezena`, `centena`  out  4 each  BCD digits of the last OUT; reset 0.
- `overflow`  out  1  last OUT value exceeded 999; reset 0.

## Operation
- Button path: a 2-flop synchronizer always, then the debounce filter (see Configuration), then a rising-edge detector on the debounced level.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, CONVERT, DONE, WAIT_CLEAR.
- IDLE:
  - 01 goes to WAIT_PRESS.
  - 10 loads the shift register and goes to CONVERT.
  - 00 and 11 stay in IDLE.
- WAIT_PRESS: on a debounced rising edge, latch `{28'b0, entradaDeDados}` into `dadosLidos` and go to WAIT_RELEASE.
- WAIT_RELEASE: stay until the debounced level is 0, then go to DONE. A held button therefore produces exactly one read.
- CONVERT (OUT):
  - Value > 999: skip the shifts. Next edge goes to DONE with digits 9/9/9 and `overflow`=1.
  - Otherwise: double-dabble on the low 10 bits, one shift per cycle for exactly 10 cycles. Before each shift, add 3 to any BCD nibble ≥ 5. The final edge goes to DONE and updates digits with `overflow`=0.
- DONE: `pronto`=1 for this one cycle, then go to WAIT_CLEAR.
- WAIT_CLEAR: stay until `entradaSaidaControl`==00 for one sampled edge, then go to IDLE. This prevents re-triggering while the CPU still presents the command.
- Command changes after acceptance are ignored until IDLE is reached again.
- Digits and `overflow` change only on entry to DONE from CONVERT. `dadosLidos` changes only on the IN latch.

## Timing
- `ocupado` = (state ≠ IDLE and state ≠ WAIT_CLEAR). It rises on the accepting edge E0.
- OUT ≤ 999: shifts on E1..E10. E10 enters DONE, so `pronto` is high between E10 and E11 and digits are valid from E10.
- OUT > 999: DONE is entered at E1.
- IN latency: button synchronizer (2 cycles) + debounce filter + 1 edge-detect cycle after a clean press, then release handling.
- Reset mid-operation (any state): return to IDLE and clear all outputs. An in-progress OUT leaves the digits at 0.

## Configuration
- `IO_DEBOUNCE_EN` defined: the debounced level changes only after the synchronized button differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the counter.
- Not defined: the debounced level equals the synchronized level directly, and `DEBOUNCE_CYCLES` is unused.

## Structure
- Shared package `io_pkg`:
  - state enumeration;
  - command codes `IO_CTRL_IDLE`/`IO_CTRL_IN`/`IO_CTRL_OUT`;
  - `BCD_LIMIT` = 999;
  - `BCD_SHIFTS` = 10.
- One sub-module, `filtro_botao`: synchronizer, debounce counter under the macro, and rising-edge pulse output.
- The FSM and the double-dabble datapath stay in `io_responder`.

## Test plan
- OUT 10 with `dadosEscrita`=123 → `ocupado` rises at E0, `pronto` pulses at E10, digits 1/2/3, `overflow`=0; nothing further happens until the command returns to 00.
- OUT 10 with 1500 → `pronto` at E1, digits 9/9/9, `overflow`=1. Then OUT 0 → digits 0/0/0, `overflow`=0.
- IN 01, switches 4'hB, clean press held 40 cycles (debounce on, 16 cycles) → `dadosLidos`=32'd11. `pronto` comes only after release, as a single pulse.
- IN with a bouncing press (toggles every 3 cycles for 20 cycles, then stable) → exactly one latch, taken after 16 stable cycles. With the macro off, the first synchronized high latches.
- Command 11 in IDLE → no state change, `ocupado`=0, no `pronto`.
- Reset asserted during CONVERT of 999 → outputs zero immediately. The next OUT 7 → digits 0/0/7.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the IN/OUT responder: FSM states, command codes and BCD constants.
package io_pkg;

    localparam logic [1:0] IO_CTRL_IDLE = 2'b00;
    localparam logic [1:0] IO_CTRL_IN   = 2'b01;
    localparam logic [1:0] IO_CTRL_OUT  = 2'b10;

    localparam int unsigned BCD_LIMIT  = 999;
    localparam int unsigned BCD_SHIFTS = 10;

    typedef enum logic [2:0] {
        StIdle,
        StWaitPress,
        StWaitRelease,
        StConvert,
        StDone,
        StWaitClear
    } io_state_t;

    // Double-dabble correction: any digit >= 5 gets +3 so the next shift carries correctly.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/filtro_botao.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce (IO_DEBOUNCE_EN),
// and a rising-edge pulse on the conditioned level.
module filtro_botao #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_botao,
    output logic o_nivel,
    output logic o_pulso
);

    logic r_sync1;
    logic r_sync2;
    logic r_nivel_ant;
    logic w_nivel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_botao;
            r_sync2 <= r_sync1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_nivel;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_nivel <= 1'b0;
        end else if (r_sync2 != r_nivel) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_nivel <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_nivel = r_nivel;
`else
    logic w_unused_cfg;

    assign w_nivel      = r_sync2;
    assign w_unused_cfg = (DEBOUNCE_CYCLES == 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_nivel_ant <= 1'b0;
        end else begin
            r_nivel_ant <= w_nivel;
        end
    end

    assign o_nivel = w_nivel;
    assign o_pulso = w_nivel & ~r_nivel_ant;

endmodule

// File: rtl/io_responder.sv
// Responder for CPU IN/OUT: IN waits for a button press and returns the switches, OUT converts
// the written word to three BCD digits. Debounce is compiled in with IO_DEBOUNCE_EN.
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DATA_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        entradaSaidaControl,
    input  logic [DATA_W-1:0] dadosEscrita,
    input  logic [3:0]        entradaDeDados,
    input  logic              botaoPlaca,
    output logic [DATA_W-1:0] dadosLidos,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        unidade,
    output logic [3:0]        dezena,
    output logic [3:0]        centena,
    output logic              overflow
);

    io_state_t r_state;
    io_state_t w_state_next;

    logic              w_nivel;
    logic              w_pulso;

    logic [9:0]        r_bin;
    logic [11:0]       r_bcd;
    logic [3:0]        r_cnt;
    logic              r_big;
    logic [DATA_W-1:0] r_dados;
    logic [3:0]        r_uni;
    logic [3:0]        r_dez;
    logic [3:0]        r_cen;
    logic              r_ovf;

    logic [11:0]       w_bcd_adj;
    logic [11:0]       w_bcd_shift;
    logic [9:0]        w_bin_shift;
    logic              w_last_shift;
    logic              w_accept_out;
    logic              w_unused_msb;

    filtro_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_botao(botaoPlaca),
        .o_nivel(w_nivel),
        .o_pulso(w_pulso)
    );

    // Top digit never reaches >= 8 for inputs <= 999, so its MSB is dropped by the shift.
    assign w_bcd_adj    = bcd_adjust(r_bcd);
    assign w_bcd_shift  = {w_bcd_adj[10:0], r_bin[9]};
    assign w_bin_shift  = {r_bin[8:0], 1'b0};
    assign w_unused_msb = w_bcd_adj[11];
    assign w_last_shift = (r_cnt == 4'(BCD_SHIFTS - 1));
    assign w_accept_out = (r_state == StIdle) && (entradaSaidaControl == IO_CTRL_OUT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (entradaSaidaControl == IO_CTRL_IN) begin
                    w_state_next = StWaitPress;
                end else if (entradaSaidaControl == IO_CTRL_OUT) begin
                    w_state_next = StConvert;
                end
            end
            StWaitPress: begin
                if (w_pulso) begin
                    w_state_next = StWaitRelease;
                end
            end
            StWaitRelease: begin
                if (!w_nivel) begin
                    w_state_next = StDone;
                end
            end
            StConvert: begin
                if (r_big || w_last_shift) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StWaitClear;
            end
            StWaitClear: begin
                if (entradaSaidaControl == IO_CTRL_IDLE) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_big   <= 1'b0;
            r_dados <= '0;
            r_uni   <= '0;
            r_dez   <= '0;
            r_cen   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept_out) begin
                r_bin <= dadosEscrita[9:0];
                r_bcd <= '0;
                r_cnt <= '0;
                r_big <= (dadosEscrita > DATA_W'(BCD_LIMIT));
            end

            if (r_state == StConvert) begin
                if (r_big) begin
                    r_cen <= 4'd9;
                    r_dez <= 4'd9;
                    r_uni <= 4'd9;
                    r_ovf <= 1'b1;
                end else begin
                    r_bcd <= w_bcd_shift;
                    r_bin <= w_bin_shift;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last_shift) begin
                        r_cen <= w_bcd_shift[11:8];
                        r_dez <= w_bcd_shift[7:4];
                        r_uni <= w_bcd_shift[3:0];
                        r_ovf <= 1'b0;
                    end
                end
            end

            if ((r_state == StWaitPress) && w_pulso) begin
                r_dados <= {{(DATA_W - 4){1'b0}}, entradaDeDados};
            end
        end
    end

    assign ocupado    = (r_state != StIdle) && (r_state != StWaitClear);
    assign pronto     = (r_state == StDone);
    assign dadosLidos = r_dados;
    assign unidade    = r_uni;
    assign dezena     = r_dez;
    assign centena    = r_cen;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder; expectations follow IO_DEBOUNCE_EN when defined.
module tb_io_responder;

    localparam int unsigned DATA_W = 32;

    logic              clock;
    logic              reset;
    logic [1:0]        entradaSaidaControl;
    logic [DATA_W-1:0] dadosEscrita;
    logic [3:0]        entradaDeDados;
    logic              botaoPlaca;
    logic [DATA_W-1:0] dadosLidos;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        unidade;
    logic [3:0]        dezena;
    logic [3:0]        centena;
    logic              overflow;

    int n_checks;
    int n_fail;

    io_responder #(
        .DEBOUNCE_CYCLES(16),
        .DATA_W         (DATA_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .entradaSaidaControl(entradaSaidaControl),
        .dadosEscrita       (dadosEscrita),
        .entradaDeDados     (entradaDeDados),
        .botaoPlaca         (botaoPlaca),
        .dadosLidos         (dadosLidos),
        .ocupado            (ocupado),
        .pronto             (pronto),
        .unidade            (unidade),
        .dezena             (dezena),
        .centena            (centena),
        .overflow           (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset;
        #1;
        n_checks++;
        if (dadosLidos !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_dadosLidos: got %0h expected 0", dadosLidos);
        end
        n_checks++;
        if ({ocupado, pronto} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got ocupado=%b pronto=%b expected 0 0", ocupado, pronto);
        end
        n_checks++;
        if ({centena, dezena, unidade, overflow} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_digits: got %h%h%h ovf=%b expected 000 ovf=0",
                     centena, dezena, unidade, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_out_123;
        int early;
        int late;
        early = 0;
        late  = 0;
        entradaSaidaControl = 2'b10;
        dadosEscrita        = 32'd123;
        @(negedge clock);
        n_checks++;
        if ({ocupado, pronto} !== 2'b10) begin
            n_fail++;
            $display("FAIL out123_e0: got ocupado=%b pronto=%b expected 1 0", ocupado, pronto);
        end
        for (int k = 1; k < 10; k++) begin
            @(negedge clock);
            if (pronto) early++;
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL out123_early_pronto: got %0d pulses before E10 expected 0", early);
        end
        @(negedge clock);
        n_checks++;
        if ({ocupado, pronto} !== 2'b11) begin
            n_fail++;
            $display("FAIL out123_e10: got ocupado=%b pronto=%b expected 1 1", ocupado, pronto);
        end
        n_checks++;
        if ({centena, dezena, unidade, overflow} !== {12'h123, 1'b0}) begin
            n_fail++;
            $display("FAIL out123_digits: got %h%h%h ovf=%b expected 123 ovf=0",
                     centena, dezena, unidade, overflow);
        end
        // Command still presented: must not retrigger.
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (pronto || ocupado) late++;
        end
        n_checks++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL out123_hold: got %0d busy/pronto samples expected 0", late);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_overflow;
        int pr;
        pr = 0;
        entradaSaidaControl = 2'b10;
        dadosEscrita        = 32'd1500;
        @(negedge clock);
        n_checks++;
        if ({ocupado, pronto} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_e0: got ocupado=%b pronto=%b expected 1 0", ocupado, pronto);
        end
        @(negedge clock);
        n_checks++;
        if (pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_e1_pronto: got %b expected 1", pronto);
        end
        n_checks++;
        if ({centena, dezena, unidade, overflow} !== {12'h999, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_digits: got %h%h%h ovf=%b expected 999 ovf=1",
                     centena, dezena, unidade, overflow);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        @(negedge clock);
        entradaSaidaControl = 2'b10;
        dadosEscrita        = 32'd0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (pr !== 1) begin
            n_fail++;
            $display("FAIL out0_pronto: got %0d pulses expected 1", pr);
        end
        n_checks++;
        if ({centena, dezena, unidade, overflow} !== 13'h0) begin
            n_fail++;
            $display("FAIL out0_digits: got %h%h%h ovf=%b expected 000 ovf=0",
                     centena, dezena, unidade, overflow);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reserved;
        int busy;
        busy = 0;
        entradaSaidaControl = 2'b11;
        dadosEscrita        = 32'd555;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (ocupado || pronto) busy++;
        end
        n_checks++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL reserved_cmd: got %0d busy/pronto samples expected 0", busy);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_in_clean;
        int pr;
        pr = 0;
        entradaSaidaControl = 2'b01;
        entradaDeDados      = 4'hB;
        for (int k = 0; k < 3; k++) @(negedge clock);
        n_checks++;
        if (ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL in_clean_busy: got ocupado=%b expected 1", ocupado);
        end
        botaoPlaca = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (pr !== 0) begin
            n_fail++;
            $display("FAIL in_clean_held_pronto: got %0d pulses expected 0", pr);
        end
        n_checks++;
        if (dadosLidos !== 32'd11) begin
            n_fail++;
            $display("FAIL in_clean_data: got %0d expected 11", dadosLidos);
        end
        botaoPlaca = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (pr !== 1) begin
            n_fail++;
            $display("FAIL in_clean_release_pronto: got %0d pulses expected 1", pr);
        end
        n_checks++;
        if (ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL in_clean_done_busy: got ocupado=%b expected 0", ocupado);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_in_bounce;
        int pr;
        logic [31:0] exp_mid;
        logic [31:0] exp_end;
`ifdef IO_DEBOUNCE_EN
        exp_mid = 32'd11;
        exp_end = 32'd10;
`else
        exp_mid = 32'd5;
        exp_end = 32'd5;
`endif
        pr = 0;
        entradaSaidaControl = 2'b01;
        entradaDeDados      = 4'h5;
        for (int k = 0; k < 3; k++) @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            botaoPlaca = (((i / 3) % 2) == 0);
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (dadosLidos !== exp_mid) begin
            n_fail++;
            $display("FAIL in_bounce_mid: got %0d expected %0d", dadosLidos, exp_mid);
        end
        entradaDeDados = 4'hA;
        botaoPlaca     = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (dadosLidos !== exp_end) begin
            n_fail++;
            $display("FAIL in_bounce_data: got %0d expected %0d", dadosLidos, exp_end);
        end
        botaoPlaca = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (pr !== 1) begin
            n_fail++;
            $display("FAIL in_bounce_pronto: got %0d pulses expected 1", pr);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int pr;
        pr = 0;
        entradaSaidaControl = 2'b10;
        dadosEscrita        = 32'd1500;
        for (int k = 0; k < 3; k++) @(negedge clock);
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre_ovf: got %b expected 1", overflow);
        end
        entradaSaidaControl = 2'b10;
        dadosEscrita        = 32'd999;
        for (int k = 0; k < 5; k++) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ocupado, pronto, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_flags: got ocupado=%b pronto=%b ovf=%b expected 0 0 0",
                     ocupado, pronto, overflow);
        end
        n_checks++;
        if ({centena, dezena, unidade} !== 12'h000 || dadosLidos !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_data: got digits %h%h%h dadosLidos=%0d expected 000 and 0",
                     centena, dezena, unidade, dadosLidos);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        entradaSaidaControl = 2'b10;
        dadosEscrita        = 32'd7;
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            if (pronto) pr++;
        end
        n_checks++;
        if (pr !== 1) begin
            n_fail++;
            $display("FAIL out7_pronto: got %0d pulses expected 1", pr);
        end
        n_checks++;
        if ({centena, dezena, unidade, overflow} !== {12'h007, 1'b0}) begin
            n_fail++;
            $display("FAIL out7_digits: got %h%h%h ovf=%b expected 007 ovf=0",
                     centena, dezena, unidade, overflow);
        end
        entradaSaidaControl = 2'b00;
        @(negedge clock);
    endtask

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        reset               = 1'b1;
        entradaSaidaControl = 2'b00;
        dadosEscrita        = '0;
        entradaDeDados      = 4'h0;
        botaoPlaca          = 1'b0;
        test_reset();
        test_out_123();
        test_overflow();
        test_reserved();
        test_in_clean();
        test_in_bounce();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
